// File: rtl/gray_sync_decoder_pkg.sv
// Shared definitions for the Gray-code synchronizer/decoder: FSM encoding,
// default geometry and error-counter width.
package gray_sync_decoder_pkg;

    localparam int GSD_DEF_N           = 4;
    localparam int GSD_DEF_SYNC_STAGES = 2;
    localparam int GSD_ERR_W           = 8;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_FAULT   = 2'd2
    } gsd_state_e;

endpackage

// File: rtl/gray_sync_decoder_gray2bin.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of all
// Gray bits at or above its position.
module gray2bin_N #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray_i,
    output logic [N-1:0] bin_o
);

    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[N-1:i];
    end

endmodule

// File: rtl/gray_sync_decoder.sv
// Synchronizes an asynchronous Gray count into the clk domain, accepts only
// legal +1 steps, decodes to binary and latches a fault on any illegal step.
module gray_sync_decoder
    import gray_sync_decoder_pkg::*;
#(
    parameter int N           = GSD_DEF_N,
    parameter int SYNC_STAGES = GSD_DEF_SYNC_STAGES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         gray_in,
    input  logic                 clear_err,
    output logic [N-1:0]         bin_out,
    output logic                 bin_valid,
    output logic                 wrap,
    output logic                 step_err,
    output logic [GSD_ERR_W-1:0] err_cnt,
    output logic                 acq_busy
);

    localparam int                FILL_W    = $clog2(SYNC_STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SYNC_STAGES);
    localparam logic [N-1:0]      ONE_N     = N'(1);
    localparam logic [N-1:0]      MAX_N     = '1;
    localparam logic [GSD_ERR_W-1:0] ERR_MAX = '1;

    logic [N-1:0]         sync_q [SYNC_STAGES];
    logic [N-1:0]         s_gray;
    logic [N-1:0]         s_bin;
    logic [N-1:0]         p_bin;
    gsd_state_e           state_q, state_d;
    logic [FILL_W-1:0]    fill_q, fill_d;
    logic [N-1:0]         p_q, p_d;
    logic [N-1:0]         bin_q, bin_d;
    logic                 vld_q, vld_d;
    logic                 wrap_q, wrap_d;
    logic [GSD_ERR_W-1:0] err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= gray_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign s_gray = sync_q[SYNC_STAGES-1];

    gray2bin_N #(.N(N)) u_s_conv (.gray_i(s_gray), .bin_o(s_bin));
    gray2bin_N #(.N(N)) u_p_conv (.gray_i(p_q),    .bin_o(p_bin));

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        p_d     = p_q;
        bin_d   = bin_q;
        vld_d   = 1'b0;
        wrap_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            ST_ACQUIRE: begin
                // After a FAULT clear the counter is preloaded full, so the load is immediate.
                if (fill_q == FILL_FULL) begin
                    p_d     = s_gray;
                    bin_d   = s_bin;
                    vld_d   = 1'b1;
                    state_d = ST_TRACK;
                end else begin
                    fill_d = fill_q + FILL_W'(1);
                end
            end
            ST_TRACK: begin
                if (s_gray != p_q) begin
                    if ($countones(s_gray ^ p_q) == 1 && s_bin == p_bin + ONE_N) begin
                        p_d    = s_gray;
                        bin_d  = s_bin;
                        vld_d  = 1'b1;
                        wrap_d = (p_bin == MAX_N);
                    end else begin
                        state_d = ST_FAULT;
                        if (err_q != ERR_MAX) err_d = err_q + GSD_ERR_W'(1);
                    end
                end
            end
            ST_FAULT: begin
                if (clear_err) begin
                    state_d = ST_ACQUIRE;
                    fill_d  = FILL_FULL;
                end
            end
            default: state_d = ST_ACQUIRE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACQUIRE;
            fill_q  <= '0;
            p_q     <= '0;
            bin_q   <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            p_q     <= p_d;
            bin_q   <= bin_d;
            vld_q   <= vld_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign bin_out   = bin_q;
    assign bin_valid = vld_q;
    assign wrap      = wrap_q;
    assign err_cnt   = err_q;
    assign step_err  = (state_q == ST_FAULT);
    assign acq_busy  = (state_q == ST_ACQUIRE);

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Scoreboard bench for gray_sync_decoder: expected decoded values are queued
// when gray_in is driven and popped by a monitor on every bin_valid pulse.
module tb_gray_sync_decoder;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] gray_in;
    logic         clear_err;
    logic [N-1:0] bin_out;
    logic         bin_valid;
    logic         wrap;
    logic         step_err;
    logic [7:0]   err_cnt;
    logic         acq_busy;

    gray_sync_decoder #(.N(N), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .gray_in   (gray_in),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .bin_valid (bin_valid),
        .wrap      (wrap),
        .step_err  (step_err),
        .err_cnt   (err_cnt),
        .acq_busy  (acq_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int bin;
        int wr;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   pulses = 0;
    int   wraps = 0;
    bit   se_seen = 1'b0;
    int   cur = 0;
    int   errs = 0;

    function automatic logic [N-1:0] to_gray(input int b);
        int m;
        m = b % 16;
        return N'(m ^ (m >> 1));
    endfunction

    function automatic int from_gray(input logic [N-1:0] g);
        for (int b = 0; b < 16; b++) if (to_gray(b) == g) return b;
        return -1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (step_err) se_seen = 1'b1;
            if (wrap && !bin_valid) chk("wrap_without_valid", 1, 0);
            if (bin_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", int'(bin_out), -1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("bin_out", int'(bin_out), e.bin);
                    chk("wrap", int'(wrap), e.wr);
                    pulses++;
                    if (wrap) wraps++;
                end
            end
        end
    end

    task automatic settle(input logic [N-1:0] g);
        gray_in = g;
        repeat (4) @(negedge clk);
    endtask

    task automatic step_ok();
        int nb;
        nb = (cur + 1) % 16;
        q.push_back('{bin: nb, wr: (cur == 15) ? 1 : 0});
        settle(to_gray(nb));
        cur = nb;
    endtask

    task automatic step_bad(input logic [N-1:0] g);
        settle(g);
        if (errs < 255) errs++;
        chk("fault_step_err", int'(step_err), 1);
        chk("fault_err_cnt", int'(err_cnt), errs);
        chk("fault_bin_hold", int'(bin_out), cur);
    endtask

    task automatic recover(input logic [N-1:0] g);
        gray_in = g;
        repeat (3) @(negedge clk);
        clear_err = 1'b1;
        q.push_back('{bin: from_gray(g), wr: 0});
        @(negedge clk);
        clear_err = 1'b0;
        chk("clear_step_err", int'(step_err), 0);
        chk("clear_acq_busy", int'(acq_busy), 1);
        @(negedge clk);
        chk("reacq_acq_busy", int'(acq_busy), 0);
        cur = from_gray(g);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bin_out"}, int'(bin_out), 0);
        chk({tag, "_bin_valid"}, int'(bin_valid), 0);
        chk({tag, "_wrap"}, int'(wrap), 0);
        chk({tag, "_step_err"}, int'(step_err), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_acq_busy"}, int'(acq_busy), 1);
    endtask

    task automatic release_check();
        q.push_back('{bin: from_gray(gray_in), wr: 0});
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            chk("acq_valid_edge", int'(bin_valid), (e == 3) ? 1 : 0);
            chk("acq_busy_edge", int'(acq_busy), (e < 3) ? 1 : 0);
        end
        cur = from_gray(gray_in);
        errs = 0;
        chk("acq_err_cnt", int'(err_cnt), 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, w0, r, nb;
        reset = 1'b1;
        gray_in = '0;
        clear_err = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_check();

        // full walk through every code, one per 4 clocks
        p0 = pulses; w0 = wraps; se_seen = 1'b0;
        for (int k = 0; k < 16; k++) step_ok();
        chk("walk_pulses", pulses - p0, 16);
        chk("walk_wraps", wraps - w0, 1);
        chk("walk_step_err_seen", int'(se_seen), 0);
        chk("walk_final_bin", int'(bin_out), 0);

        // two-bit jump from bin 3, then recovery into bin 4
        repeat (3) step_ok();
        step_bad(4'b0111);
        recover(4'b0110);
        chk("recover_bin4", int'(bin_out), 4);

        // clear_err in TRACK must be inert
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        repeat (4) @(negedge clk);
        chk("track_clear_step_err", int'(step_err), 0);
        chk("track_clear_acq_busy", int'(acq_busy), 0);
        step_ok();

        // accumulate to 5 faults, then async reset while in FAULT
        for (int k = 0; k < 4; k++) begin
            step_bad(to_gray(cur + 2));
            if (k < 3) recover(to_gray($urandom_range(0, 15)));
        end
        chk("pre_reset_err_cnt", int'(err_cnt), 5);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset");
        @(negedge clk);
        release_check();

        // randomized legal/illegal steps
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7) begin
                step_ok();
            end else begin
                do nb = $urandom_range(0, 15);
                while (nb == cur || nb == (cur + 1) % 16);
                step_bad(to_gray(nb));
                recover(to_gray($urandom_range(0, 15)));
            end
        end

        // saturation: backward one-bit step 0011 -> 0001 repeated
        step_bad(to_gray(cur + 2));
        for (int k = 0; k < 300; k++) begin
            recover(4'b0011);
            step_bad(4'b0001);
        end
        chk("err_cnt_saturated", int'(err_cnt), 255);
        chk("scoreboard_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
